// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the fetch/decode/execute controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        EXEC1   = 3'd3,
        EXEC2   = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OPC_LD   = 4'h0;
    localparam logic [3:0] OPC_ST   = 4'h1;
    localparam logic [3:0] OPC_MOVI = 4'h2;
    localparam logic [3:0] OPC_INC  = 4'h3;
    localparam logic [3:0] OPC_DEC  = 4'h4;
    localparam logic [3:0] OPC_CLR  = 4'h5;
    localparam logic [3:0] OPC_BRA  = 4'h6;
    localparam logic [3:0] OPC_ADD  = 4'h7;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0100;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_IR   = 2'b10;
    localparam logic [1:0] SRC_ARFA = 2'b11;

    // ARF enables and output selects
    localparam logic [3:0] ARF_EN_AR  = 4'b1000;
    localparam logic [3:0] ARF_EN_PC  = 4'b0001;
    localparam logic [1:0] ARF_SEL_AR = 2'b00;
    localparam logic [1:0] ARF_SEL_PC = 2'b11;

    // Full control word driven onto the datapath
    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_IR;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] rf_tsel;
        logic [3:0] regsel_arf;
        logic       wrMEM;
        logic       csMEM;
        logic       IR_enable;
        logic       IR_lh;
        logic [1:0] MUXSelA;
        logic [1:0] MUXSelB;
        logic       MUXSelC;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
    } ctrl_t;

    // Idle control word: memory deselected, nothing enabled
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c       = '0;
        c.csMEM = 1'b1;
        return c;
    endfunction

    // R1..R4 enable mask, R1 on bit 3
    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    function automatic logic is_two_exec(input logic [3:0] opc);
        return (opc == OPC_LD) || (opc == OPC_ST);
    endfunction

    function automatic logic is_legal(input logic [3:0] opc);
        return (opc <= OPC_ADD) || (opc == OPC_HALT);
    endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational decode of (state, IR) into the datapath control word.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int CLEAR_RF = 1
) (
    input  state_t      state,
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    logic [3:0] opc;
    logic [1:0] rx;
    logic [1:0] ry;

    assign opc = ir[15:12];
    assign rx  = ir[11:10];
    assign ry  = ir[9:8];

    // Control word per state; HALT opcode and undefined opcodes stay idle
    always_comb begin
        ctrl = idle_ctrl();
        case (state)
            INIT: begin
                ctrl.funsel_arf = FS_CLR;
                ctrl.regsel_arf = ARF_EN_PC;
                ctrl.IR_enable  = 1'b1;
                ctrl.funsel_IR  = FS_CLR;
                if (CLEAR_RF != 0) begin
                    ctrl.funsel_rf = FS_CLR;
                    ctrl.regsel_rf = '1;
                    ctrl.rf_tsel   = '1;
                end
            end
            FETCH_L, FETCH_H: begin
                ctrl.outbsel    = ARF_SEL_PC;
                ctrl.csMEM      = 1'b0;
                ctrl.IR_enable  = 1'b1;
                ctrl.funsel_IR  = FS_LOAD;
                ctrl.IR_lh      = (state == FETCH_H);
                ctrl.funsel_arf = FS_INC;
                ctrl.regsel_arf = ARF_EN_PC;
            end
            EXEC1: begin
                case (opc)
                    OPC_LD, OPC_ST: begin
                        ctrl.MUXSelB    = SRC_IR;
                        ctrl.regsel_arf = ARF_EN_AR;
                        ctrl.funsel_arf = FS_LOAD;
                    end
                    OPC_MOVI: begin
                        ctrl.MUXSelA   = SRC_IR;
                        ctrl.funsel_rf = FS_LOAD;
                        ctrl.regsel_rf = rf_onehot(rx);
                    end
                    OPC_INC: begin
                        ctrl.funsel_rf = FS_INC;
                        ctrl.regsel_rf = rf_onehot(rx);
                    end
                    OPC_DEC: begin
                        ctrl.funsel_rf = FS_DEC;
                        ctrl.regsel_rf = rf_onehot(rx);
                    end
                    OPC_CLR: begin
                        ctrl.funsel_rf = FS_CLR;
                        ctrl.regsel_rf = rf_onehot(rx);
                    end
                    OPC_BRA: begin
                        ctrl.MUXSelB    = SRC_IR;
                        ctrl.regsel_arf = ARF_EN_PC;
                        ctrl.funsel_arf = FS_LOAD;
                    end
                    OPC_ADD: begin
                        ctrl.rf_o1sel   = {1'b1, rx};
                        ctrl.rf_o2sel   = {1'b1, ry};
                        ctrl.MUXSelC    = 1'b0;
                        ctrl.funsel_alu = ALU_ADD;
                        ctrl.MUXSelA    = SRC_ALU;
                        ctrl.funsel_rf  = FS_LOAD;
                        ctrl.regsel_rf  = rf_onehot(rx);
                    end
                    default: ;
                endcase
            end
            EXEC2: begin
                case (opc)
                    OPC_LD: begin
                        ctrl.outbsel   = ARF_SEL_AR;
                        ctrl.csMEM     = 1'b0;
                        ctrl.MUXSelA   = SRC_MEM;
                        ctrl.funsel_rf = FS_LOAD;
                        ctrl.regsel_rf = rf_onehot(rx);
                    end
                    OPC_ST: begin
                        ctrl.outbsel    = ARF_SEL_AR;
                        ctrl.csMEM      = 1'b0;
                        ctrl.wrMEM      = 1'b1;
                        ctrl.MUXSelC    = 1'b0;
                        ctrl.rf_o1sel   = {1'b1, rx};
                        ctrl.funsel_alu = ALU_PASS_A;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute controller: state register, next-state
// logic and reset-gated drive of the decoded control word.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int CLEAR_RF        = 1,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR_out,
    output logic [1:0]  outasel,
    output logic [1:0]  outbsel,
    output logic [1:0]  funsel_IR,
    output logic [1:0]  funsel_arf,
    output logic [1:0]  funsel_rf,
    output logic [3:0]  funsel_alu,
    output logic [3:0]  regsel_rf,
    output logic [3:0]  rf_tsel,
    output logic [3:0]  regsel_arf,
    output logic        wrMEM,
    output logic        csMEM,
    output logic        IR_enable,
    output logic        IR_lh,
    output logic [1:0]  MUXSelA,
    output logic [1:0]  MUXSelB,
    output logic        MUXSelC,
    output logic [2:0]  rf_o1sel,
    output logic [2:0]  rf_o2sel,
    output logic        halted,
    output logic [2:0]  state_o
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      dec;
    ctrl_t      drv;
    logic [3:0] opc;

    assign opc = IR_out[15:12];

    ctrl_decode #(
        .CLEAR_RF(CLEAR_RF)
    ) u_decode (
        .state(state_q),
        .ir   (IR_out),
        .ctrl (dec)
    );

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) state_q <= INIT;
        else       state_q <= state_d;
    end

    // Next-state sequencing; HALT is left only through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = FETCH_L;
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = EXEC1;
            EXEC1: begin
                if (opc == OPC_HALT || (!is_legal(opc) && HALT_ON_ILLEGAL != 0))
                    state_d = HALT;
                else if (is_two_exec(opc))
                    state_d = EXEC2;
                else
                    state_d = FETCH_L;
            end
            EXEC2:   state_d = FETCH_L;
            HALT:    state_d = HALT;
            default: state_d = INIT;
        endcase
    end

    // Reset forces idle so an abandoned instruction cannot write in the reset cycle
    always_comb begin
        drv = reset ? idle_ctrl() : dec;
    end

    assign outasel    = drv.outasel;
    assign outbsel    = drv.outbsel;
    assign funsel_IR  = drv.funsel_IR;
    assign funsel_arf = drv.funsel_arf;
    assign funsel_rf  = drv.funsel_rf;
    assign funsel_alu = drv.funsel_alu;
    assign regsel_rf  = drv.regsel_rf;
    assign rf_tsel    = drv.rf_tsel;
    assign regsel_arf = drv.regsel_arf;
    assign wrMEM      = drv.wrMEM;
    assign csMEM      = drv.csMEM;
    assign IR_enable  = drv.IR_enable;
    assign IR_lh      = drv.IR_lh;
    assign MUXSelA    = drv.MUXSelA;
    assign MUXSelB    = drv.MUXSelB;
    assign MUXSelC    = drv.MUXSelC;
    assign rf_o1sel   = drv.rf_o1sel;
    assign rf_o2sel   = drv.rf_o2sel;
    assign halted     = (state_q == HALT);
    assign state_o    = state_q;

endmodule
